rom_arbiter: RTL and testbench

//   Shares the 512x64-byte line ROM between two 32-bit word requesters: req0 (instruction fetch) and req1 (data load).

---
 rtl/rom_pkg.sv | 20 ++
 rtl/rom_line_buf.sv | 49 ++++
 rtl/rom_arbiter.sv | 156 +++++++++++++++
 tb/tb_rom_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// Shared constants and types for the line-ROM arbiter.
//   ROM_ADDR_W  byte address width of the 32 KiB ROM
//   LINE_BYTES  bytes per ROM line; LINE_IDX_W bits select one of 512 lines
//   WORD_SEL_W  bits selecting one 32-bit word inside a line
package rom_pkg;
  localparam int ROM_ADDR_W  = 15;
  localparam int LINE_BYTES  = 64;
  localparam int LINE_IDX_W  = 9;
  localparam int WORD_SEL_W  = 4;
  localparam int LINE_OFF_W  = 6;
  localparam int ROM_LINE_W  = LINE_BYTES * 8;
  localparam int ROM_WORD_W  = 32;
  localparam int ROM_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } rom_arb_state_t;
endpackage

// File: rtl/rom_line_buf.sv
// One-entry ROM line buffer: tag, valid bit and the full line.
//   clk, rst_n   clock / async active-low reset (buffer invalid after reset)
//   load         capture load_line under load_tag and mark valid
//   clear        invalidate the entry
//   look_tag     tag compared against the stored one -> hit
//   word_sel     selects the 32-bit word returned on word
module rom_line_buf
  import rom_pkg::*;
#(
  parameter int TAG_W  = LINE_IDX_W,
  parameter int LINE_W = ROM_LINE_W,
  parameter int WORD_W = ROM_WORD_W,
  parameter int SEL_W  = WORD_SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [TAG_W-1:0]  load_tag,
  input  logic [LINE_W-1:0] load_line,
  input  logic [TAG_W-1:0]  look_tag,
  input  logic [SEL_W-1:0]  word_sel,
  output logic              hit,
  output logic [WORD_W-1:0] word
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      line_q  <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      tag_q   <= load_tag;
      line_q  <= load_line;
    end
  end

  assign hit  = valid_q && (tag_q == look_tag);
  // Byte k of the line sits at [8k+7:8k], so word w is simply the w-th 32-bit slice.
  assign word = line_q[word_sel*WORD_W +: WORD_W];

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing the line ROM between two word requesters
// (req0 = instruction fetch, req1 = data load), with a one-line buffer.
//   clk, rst_n                 clock / async active-low reset
//   reqN_valid/addr/ready      request handshake; ready is combinational
//   rspN_valid/err/data        one-cycle response pulse per accepted request
//   rom_cs/addr_valid/addr     ROM bus, driven only while fetching
//   rom_data_ready/rom_data    ROM line return, looked at only while fetching
//
// state | meaning
// IDLE  | no transaction; grants the next requester
// FETCH | ROM line read in flight; waits for rom_data_ready or timeout
// RESP  | one-cycle response to the granted requester
module rom_arbiter
  import rom_pkg::*;
#(
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int LINE_W  = ROM_LINE_W,
  parameter int WORD_W  = ROM_WORD_W,
  parameter int TIMEOUT = ROM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic              rsp0_err,
  output logic [WORD_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic              rsp1_err,
  output logic [WORD_W-1:0] rsp1_data,
  output logic              rom_cs,
  output logic              rom_addr_valid,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_data_ready,
  input  logic [LINE_W-1:0] rom_data
);

  localparam int TAG_W  = ADDR_W - LINE_OFF_W;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  rom_arb_state_t    state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              err_q, err_d;
  logic              last_gnt_q;  // 1: req1 was granted last
  logic              id_q;
  logic [ADDR_W-1:0] addr_q;

  logic              gnt_any, gnt_id;
  logic [ADDR_W-1:0] gnt_addr;
  logic              buf_hit, buf_load;
  logic [WORD_W-1:0] buf_word, rsp_word;
  logic              unused_addr_lsb;

  always_comb begin
    gnt_id = req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_gnt_q;
  end

  assign gnt_any    = (state_q == IDLE) && (req0_valid || req1_valid);
  assign gnt_addr   = gnt_id ? req1_addr : req0_addr;
  assign req0_ready = gnt_any && !gnt_id;
  assign req1_ready = gnt_any && gnt_id;

  rom_line_buf #(
    .TAG_W  (TAG_W),
    .LINE_W (LINE_W),
    .WORD_W (WORD_W),
    .SEL_W  (WORD_SEL_W)
  ) u_line_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (buf_load),
    // The ROM is read-only, so a captured line never goes stale.
    .clear     (1'b0),
    .load_tag  (addr_q[ADDR_W-1:LINE_OFF_W]),
    .load_line (rom_data),
    .look_tag  (gnt_addr[ADDR_W-1:LINE_OFF_W]),
    .word_sel  (addr_q[LINE_OFF_W-1:2]),
    .hit       (buf_hit),
    .word      (buf_word)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    err_d    = err_q;
    buf_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          err_d = 1'b0;
          if (buf_hit) begin
            state_d = RESP;
          end else begin
            state_d = FETCH;
            wait_d  = WAIT_W'(TIMEOUT - 1);
          end
        end
      end
      FETCH: begin
        // A line arriving on the last allowed cycle still wins over the timeout.
        if (rom_data_ready) begin
          buf_load = 1'b1;
          state_d  = RESP;
        end else if (wait_q == '0) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      err_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      id_q       <= 1'b0;
      addr_q     <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      if (gnt_any) begin
        last_gnt_q <= gnt_id;
        id_q       <= gnt_id;
        addr_q     <= gnt_addr;
      end
    end
  end

  assign rom_cs         = (state_q == FETCH);
  assign rom_addr_valid = (state_q == FETCH);
  assign rom_addr       = rom_cs ? {addr_q[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)} : '0;

  assign rsp_word   = err_q ? '0 : buf_word;
  assign rsp0_valid = (state_q == RESP) && !id_q;
  assign rsp1_valid = (state_q == RESP) && id_q;
  assign rsp0_err   = rsp0_valid && err_q;
  assign rsp1_err   = rsp1_valid && err_q;
  assign rsp0_data  = rsp0_valid ? rsp_word : '0;
  assign rsp1_data  = rsp1_valid ? rsp_word : '0;

  // Word-aligned access: the byte offset inside a word is don't-care.
  assign unused_addr_lsb = ^addr_q[1:0];

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;
  import rom_pkg::*;

  localparam int TO = ROM_TIMEOUT;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  req0_valid, req1_valid;
  logic [ROM_ADDR_W-1:0] req0_addr, req1_addr;
  logic                  req0_ready, req1_ready;
  logic                  rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [ROM_WORD_W-1:0] rsp0_data, rsp1_data;
  logic                  rom_cs, rom_addr_valid, rom_data_ready;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [ROM_LINE_W-1:0] rom_data;

  rom_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_addr      (req0_addr),
    .req0_ready     (req0_ready),
    .rsp0_valid     (rsp0_valid),
    .rsp0_err       (rsp0_err),
    .rsp0_data      (rsp0_data),
    .req1_valid     (req1_valid),
    .req1_addr      (req1_addr),
    .req1_ready     (req1_ready),
    .rsp1_valid     (rsp1_valid),
    .rsp1_err       (rsp1_err),
    .rsp1_data      (rsp1_data),
    .rom_cs         (rom_cs),
    .rom_addr_valid (rom_addr_valid),
    .rom_addr       (rom_addr),
    .rom_data_ready (rom_data_ready),
    .rom_data       (rom_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents: byte k of line L
  function automatic logic [7:0] rom_byte(input int line, input int k);
    return 8'((line * 37 + k * 11 + (line >> 2) * 5 + 3) & 255);
  endfunction

  always_comb begin
    rom_data = '0;
    for (int k = 0; k < LINE_BYTES; k++)
      rom_data[8*k +: 8] = rom_byte(int'(rom_addr[14:6]), k);
  end

  // Expected word: little-endian assembly of bytes 4w..4w+3 of the line
  function automatic logic [31:0] exp_word(input int addr);
    int line;
    int ws;
    logic [31:0] w;
    line = addr >> 6;
    ws   = (addr >> 2) & 15;
    w    = '0;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = rom_byte(line, 4 * ws + b);
    return w;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: one outstanding transaction described by its accept
  // period and the period in which its response is due.
  bit pend;
  int p_id, p_addr, p_acc, p_rsp, p_d;
  bit p_err;
  bit buf_v;
  int buf_tag;
  int last_gnt;
  bit gen_v[2];
  int gen_a[2];
  bit gen_en;
  int force_d;

  function automatic int rand_addr();
    int sel;
    sel = int'($urandom_range(0, 5));
    case (sel)
      0: return (0 << 6) | int'($urandom_range(0, 63));
      1: return (1 << 6) | int'($urandom_range(0, 63));
      2: return (2 << 6) | int'($urandom_range(0, 63));
      3: return (511 << 6) | int'($urandom_range(0, 63));
      4: return (int'($urandom_range(3, 127)) << 6) | int'($urandom_range(0, 63));
      default: return 'h7FFF;
    endcase
  endfunction

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    if (r < 8) return int'($urandom_range(4, TO - 1));
    return 99;
  endfunction

  task automatic step();
    int q;
    int winner;
    int line;
    bit fetch;
    bit rv;
    logic [31:0] ea;
    @(negedge clk);
    q = cyc;
    if (pend && q > p_rsp) pend = 0;

    fetch = pend && (q >= p_acc + 1) && (q < p_rsp);
    ea    = fetch ? 32'(p_addr & 'h7FC0) : 32'd0;
    check("rom_cs", 32'(rom_cs), 32'(fetch));
    check("rom_addr_valid", 32'(rom_addr_valid), 32'(fetch));
    check("rom_addr", 32'(rom_addr), ea);

    rv = pend && (q == p_rsp) && (p_id == 0);
    check("rsp0_valid", 32'(rsp0_valid), 32'(rv));
    check("rsp0_err", 32'(rsp0_err), 32'(rv && p_err));
    check("rsp0_data", rsp0_data, (rv && !p_err) ? exp_word(p_addr) : 32'd0);
    rv = pend && (q == p_rsp) && (p_id == 1);
    check("rsp1_valid", 32'(rsp1_valid), 32'(rv));
    check("rsp1_err", 32'(rsp1_err), 32'(rv && p_err));
    check("rsp1_data", rsp1_data, (rv && !p_err) ? exp_word(p_addr) : 32'd0);

    for (int i = 0; i < 2; i++)
      if (!gen_v[i] && gen_en && $urandom_range(0, 2) != 0) begin
        gen_v[i] = 1;
        gen_a[i] = rand_addr();
      end
    req0_valid = gen_v[0];
    req0_addr  = 15'(gen_a[0]);
    req1_valid = gen_v[1];
    req1_addr  = 15'(gen_a[1]);
    rom_data_ready = fetch ? ((q - p_acc - 1) == p_d) : 1'($urandom_range(0, 1));

    #1;
    winner = -1;
    if (!pend && (gen_v[0] || gen_v[1]))
      winner = (gen_v[0] && gen_v[1]) ? 1 - last_gnt : (gen_v[0] ? 0 : 1);
    check("req0_ready", 32'(req0_ready), 32'(winner == 0));
    check("req1_ready", 32'(req1_ready), 32'(winner == 1));
    if (winner >= 0) begin
      last_gnt = winner;
      gen_v[winner] = 0;
      pend   = 1;
      p_id   = winner;
      p_addr = gen_a[winner];
      p_acc  = q;
      line   = p_addr >> 6;
      if (buf_v && buf_tag == line) begin
        p_err = 0;
        p_d   = 0;
        p_rsp = q + 1;
      end else begin
        p_d = (force_d >= 0) ? force_d : pick_delay();
        force_d = -1;
        if (p_d < TO) begin
          p_err   = 0;
          p_rsp   = q + 2 + p_d;
          buf_v   = 1;
          buf_tag = line;
        end else begin
          p_err = 1;
          p_rsp = q + 1 + TO;
        end
      end
    end
  endtask

  task automatic model_reset();
    pend     = 0;
    buf_v    = 0;
    buf_tag  = 0;
    last_gnt = 1;
    gen_v[0] = 0;
    gen_v[1] = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    req0_addr = '0; req1_addr = '0;
    rom_data_ready = 0;
    gen_en  = 0;
    force_d = -1;
    gen_a[0] = 0; gen_a[1] = 0;
    p_id = 0; p_addr = 0; p_acc = 0; p_rsp = 0; p_d = 0; p_err = 0;
    model_reset();

    #12;
    check("reset_rom_cs", 32'(rom_cs), 32'd0);
    check("reset_rom_addr_valid", 32'(rom_addr_valid), 32'd0);
    check("reset_rom_addr", 32'(rom_addr), 32'd0);
    check("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("reset_rsp0_data", rsp0_data, 32'd0);
    check("reset_rsp1_data", rsp1_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // word at 0x0004 fetched with ROM ready on the first cycle, then a hit at 0x003C
    gen_v[0] = 1; gen_a[0] = 'h0004; force_d = 0;
    repeat (4) step();
    gen_v[1] = 1; gen_a[1] = 'h003C;
    repeat (4) step();
    // both requesters alternating on two lines that evict each other
    gen_v[0] = 1; gen_a[0] = 'h0040;
    gen_v[1] = 1; gen_a[1] = 'h0080;
    repeat (2) step();
    gen_v[1] = 1; gen_a[1] = 'h0080;
    repeat (4) step();
    gen_v[0] = 1; gen_a[0] = 'h0040;
    repeat (8) step();
    // a timeout on a fresh line, then the same line again
    gen_v[0] = 1; gen_a[0] = 'h1000; force_d = 99;
    repeat (18) step();
    gen_v[1] = 1; gen_a[1] = 'h1004; force_d = 0;
    repeat (4) step();

    gen_en = 1;
    repeat (1500) step();

    // reset in the middle of a fetch
    gen_en = 0;
    repeat (40) step();
    gen_v[0] = 1; gen_a[0] = 'h0008; force_d = 0;
    repeat (5) step();
    gen_v[0] = 1; gen_a[0] = 'h5000; force_d = 99;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    check("midreset_rom_cs", 32'(rom_cs), 32'd0);
    check("midreset_rom_addr_valid", 32'(rom_addr_valid), 32'd0);
    check("midreset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("midreset_rsp1_valid", 32'(rsp1_valid), 32'd0);
    req0_valid = 0; req1_valid = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    gen_v[0] = 1; gen_a[0] = 'h0020;
    gen_v[1] = 1; gen_a[1] = 'h0010;
    force_d = 0;
    repeat (4) step();
    gen_en = 1;
    repeat (400) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
